// File: rtl/microcode_sequencer.sv
// Microcode sequencer: a writable microcode store, a small call/return stack and
// an IDLE/FETCH/ISSUE controller that hands microwords out over a valid/ready port.
module microcode_sequencer #(
  parameter int UADDR_W     = 8,
  parameter int UWORD_W     = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic [UADDR_W-1:0] ld_addr,
  input  logic [UWORD_W-1:0] ld_data,
  input  logic               start,
  input  logic [UADDR_W-1:0] entry_addr,
  output logic               start_ready,
  input  logic               cond,
  output logic [UWORD_W-1:0] uinstr,
  output logic               uvalid,
  input  logic               uready,
  output logic [UADDR_W-1:0] upc,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Stack pointer counts entries 0..STACK_DEPTH, so it needs one extra code
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_BRZ  = 3'b100;
  localparam logic [2:0] OP_END  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [UWORD_W-1:0] store [2**UADDR_W];
  logic [UADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]    sp;

  logic [2:0]         op;
  logic [UADDR_W-1:0] target;
  logic [UADDR_W-1:0] upc_inc;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;
  logic               handshake;
  logic               stack_full;
  logic               stack_empty;

  assign op          = uinstr[UWORD_W-1 -: 3];
  assign target      = uinstr[UWORD_W-4 -: UADDR_W];
  assign upc_inc     = upc + UADDR_W'(1);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));
  assign handshake   = (state == ISSUE) && uready;
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; END and stack faults drop back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (uready) begin
          case (op)
            OP_END:  state_nxt = IDLE;
            OP_CALL: state_nxt = stack_full ? IDLE : FETCH;
            OP_RET:  state_nxt = stack_empty ? IDLE : FETCH;
            default: state_nxt = FETCH;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b0;
    uvalid      = 1'b0;
    case (state)
      IDLE:    start_ready = 1'b1;
      FETCH:   busy        = 1'b1;
      ISSUE: begin
        busy   = 1'b1;
        uvalid = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
  end

  // Store write port, only open while idle so a running routine never sees it change
  always_ff @(posedge clk) begin
    if (ld_en && (state == IDLE)) begin
      store[ld_addr] <= ld_data;
    end
  end

  // Return-address storage; an overflowing CALL leaves the stack untouched
  always_ff @(posedge clk) begin
    if (!rst && handshake && (op == OP_CALL) && !stack_full) begin
      stack[push_idx] <= upc_inc;
    end
  end

  // Micro-PC, stack pointer, fetched word and done/err flags
  always_ff @(posedge clk) begin
    if (rst) begin
      upc    <= '0;
      sp     <= '0;
      uinstr <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            upc <= entry_addr;
            sp  <= '0;
            err <= 1'b0;
          end
        end
        FETCH: begin
          uinstr <= store[upc];
        end
        ISSUE: begin
          if (uready) begin
            case (op)
              OP_NEXT: upc <= upc_inc;
              OP_JUMP: upc <= target;
              OP_CALL: begin
                if (stack_full) begin
                  err <= 1'b1;
                end else begin
                  sp  <= sp + SP_W'(1);
                  upc <= target;
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  err <= 1'b1;
                end else begin
                  sp  <= sp - SP_W'(1);
                  upc <= stack[pop_idx];
                end
              end
              OP_BRZ:  upc  <= cond ? upc_inc : target;
              OP_END:  done <= 1'b1;
              default: upc  <= upc_inc;
            endcase
          end
        end
        default: upc <= upc;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: expected micro-addresses are queued
// before each routine launch and popped as the sequencer issues microwords.
module tb_microcode_sequencer;

  localparam int UADDR_W     = 8;
  localparam int UWORD_W     = 32;
  localparam int STACK_DEPTH = 4;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_BRZ  = 3'b100;
  localparam logic [2:0] OP_END  = 3'b101;

  logic               clk = 1'b0;
  logic               rst;
  logic               ld_en;
  logic [UADDR_W-1:0] ld_addr;
  logic [UWORD_W-1:0] ld_data;
  logic               start;
  logic [UADDR_W-1:0] entry_addr;
  logic               start_ready;
  logic               cond;
  logic [UWORD_W-1:0] uinstr;
  logic               uvalid;
  logic               uready;
  logic [UADDR_W-1:0] upc;
  logic               busy;
  logic               done;
  logic               err;

  int checks = 0;
  int errors = 0;

  logic [UADDR_W-1:0] exp_q [$];
  logic [UWORD_W-1:0] mirror [256];

  // Free-running clock
  always #5 clk = ~clk;

  microcode_sequencer #(
    .UADDR_W    (UADDR_W),
    .UWORD_W    (UWORD_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .entry_addr (entry_addr),
    .start_ready(start_ready),
    .cond       (cond),
    .uinstr     (uinstr),
    .uvalid     (uvalid),
    .uready     (uready),
    .upc        (upc),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Microword with the store address in the opaque low bits so each word is unique
  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] tgt, input logic [7:0] addr);
    return {op, tgt, 13'h0, addr};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [2:0] op, input logic [7:0] tgt);
    mirror[a] = mk(op, tgt, a);
    ld_en     = 1'b1;
    ld_addr   = a;
    ld_data   = mirror[a];
    @(negedge clk);
    ld_en     = 1'b0;
  endtask

  // Launch a routine and follow it to IDLE, popping the scoreboard at every issue.
  // With stall>0 the first microword is back-pressured for that many cycles while
  // a stray start is driven; cond only takes its handshake value at release.
  task automatic apply_stimulus(input logic [7:0] entry, input int stall, input logic cond_hs,
                                input logic exp_done, input logic exp_err);
    int cyc;
    bit first;
    logic [31:0] held;
    logic [7:0] e;
    start      = 1'b1;
    entry_addr = entry;
    uready     = (stall == 0);
    cond       = (stall == 0) ? cond_hs : ~cond_hs;
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    check_output("fetch_uvalid", uvalid, 0);
    check_output("err_cleared_on_start", err, 0);
    check_output("fetch_start_ready", start_ready, 0);
    cyc   = 0;
    first = 1'b1;
    while (busy && cyc < 80) begin
      if (uvalid) begin
        if (first) check_output("first_uvalid_latency", cyc, 1);
        if (exp_q.size() == 0) begin
          check_output("sb_unexpected_issue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_output("issue_upc", upc, e);
          check_output("issue_uinstr", uinstr, mirror[e]);
          if (first && stall > 0) begin
            held       = uinstr;
            start      = 1'b1;
            entry_addr = 8'h10;
            repeat (stall) begin
              @(negedge clk);
              check_output("stall_uvalid", uvalid, 1);
              check_output("stall_uinstr", uinstr, held);
              check_output("stall_upc", upc, e);
            end
            start  = 1'b0;
            uready = 1'b1;
            cond   = cond_hs;
          end
        end
        first = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_output("routine_end", busy, 0);
    check_output("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    check_output("end_done", done, exp_done);
    check_output("end_err", err, exp_err);
    check_output("end_uvalid", uvalid, 0);
    check_output("end_start_ready", start_ready, 1);
    @(negedge clk);
    check_output("done_one_cycle", done, 0);
    check_output("err_sticky", err, exp_err);
  endtask

  initial begin
    rst        = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    start      = 1'b0;
    entry_addr = '0;
    cond       = 1'b0;
    uready     = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_upc", upc, 0);
    check_output("rst_uinstr", uinstr, 0);
    check_output("rst_uvalid", uvalid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_start_ready", start_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] loading microcode");
    load_word(8'h10, OP_NEXT, 8'h00);
    load_word(8'h11, OP_NEXT, 8'h00);
    load_word(8'h12, OP_END,  8'h00);
    load_word(8'h00, OP_CALL, 8'h40);
    load_word(8'h40, OP_RET,  8'h00);
    load_word(8'h01, OP_END,  8'h00);
    for (int i = 0; i < 5; i++) load_word(8'h50 + 8'(i), OP_CALL, 8'h51 + 8'(i));
    load_word(8'h20, OP_BRZ,  8'h30);
    load_word(8'h30, OP_END,  8'h00);
    load_word(8'h21, OP_END,  8'h00);
    load_word(8'hFF, OP_NEXT, 8'h00);
    load_word(8'h31, OP_END,  8'h00);
    load_word(8'h32, OP_END,  8'h00);
    load_word(8'h60, OP_JUMP, 8'h10);

    $display("[TB] linear routine");
    exp_q = '{8'h10, 8'h11, 8'h12};
    apply_stimulus(8'h10, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] call and return");
    exp_q = '{8'h00, 8'h40, 8'h01};
    apply_stimulus(8'h00, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] stack overflow");
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    apply_stimulus(8'h50, 0, 1'b0, 1'b0, 1'b1);
    exp_q = '{8'h10, 8'h11, 8'h12};
    apply_stimulus(8'h10, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] branch with backpressure");
    exp_q = '{8'h20, 8'h30};
    apply_stimulus(8'h20, 5, 1'b0, 1'b1, 1'b0);
    exp_q = '{8'h20, 8'h21};
    apply_stimulus(8'h20, 5, 1'b1, 1'b1, 1'b0);

    $display("[TB] address wrap");
    exp_q = '{8'hFF, 8'h00, 8'h40, 8'h01};
    apply_stimulus(8'hFF, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] load and start in the same cycle");
    mirror[8'h60] = mk(OP_END, 8'h00, 8'h60);
    ld_en   = 1'b1;
    ld_addr = 8'h60;
    ld_data = mirror[8'h60];
    exp_q   = '{8'h60};
    apply_stimulus(8'h60, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] load ignored while running");
    start      = 1'b1;
    entry_addr = 8'h32;
    uready     = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 8'h31;
    ld_data = mk(OP_JUMP, 8'h10, 8'h31);
    @(negedge clk);
    check_output("gated_issue_uvalid", uvalid, 1);
    @(negedge clk);
    ld_en  = 1'b0;
    uready = 1'b1;
    @(negedge clk);
    check_output("gated_done", done, 1);
    @(negedge clk);
    exp_q = '{8'h31};
    apply_stimulus(8'h31, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset during issue");
    start      = 1'b1;
    entry_addr = 8'h10;
    uready     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_output("pre_reset_uvalid", uvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_upc", upc, 0);
    check_output("midrst_uinstr", uinstr, 0);
    check_output("midrst_uvalid", uvalid, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_err", err, 0);
    check_output("midrst_start_ready", start_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    exp_q = '{8'h10, 8'h11, 8'h12};
    apply_stimulus(8'h10, 0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
